// File: rtl/klotski_pkg.sv
// Shared board geometry, piece ids, opening layout and FSM encoding for the
// sliding-block board move engine.
package klotski_pkg;

    localparam int unsigned COLS    = 4;
    localparam int unsigned ROWS    = 5;
    localparam int unsigned CELLS   = 20;
    localparam int unsigned CNT_W   = 10;
    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned PIECE_W = 4;

    typedef logic [CELLS-1:0][PIECE_W-1:0] board_t;

    typedef enum logic [1:0] {
        DirUp    = 2'd0,
        DirDown  = 2'd1,
        DirLeft  = 2'd2,
        DirRight = 2'd3
    } dir_e;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoad  = 3'd1,
        StCheck = 3'd2,
        StWrite = 3'd3,
        StDone  = 3'd4
    } state_e;

    localparam logic [PIECE_W-1:0] PIECE_NONE = 4'd0;
    localparam logic [PIECE_W-1:0] PIECE_BIG  = 4'd1;  // 2x2
    localparam logic [PIECE_W-1:0] PIECE_V_A  = 4'd2;  // vertical 1x2
    localparam logic [PIECE_W-1:0] PIECE_V_B  = 4'd3;
    localparam logic [PIECE_W-1:0] PIECE_V_C  = 4'd4;
    localparam logic [PIECE_W-1:0] PIECE_H    = 4'd5;  // horizontal 2x1
    localparam logic [PIECE_W-1:0] PIECE_V_D  = 4'd6;
    localparam logic [PIECE_W-1:0] PIECE_S_A  = 4'd7;  // 1x1
    localparam logic [PIECE_W-1:0] PIECE_S_B  = 4'd8;
    localparam logic [PIECE_W-1:0] PIECE_S_C  = 4'd9;
    localparam logic [PIECE_W-1:0] PIECE_S_D  = 4'd10;
    localparam logic [PIECE_W-1:0] MAX_PIECE  = PIECE_S_D;

    // Listed from cell 19 down to cell 0 (bottom row first).
    localparam board_t OPENING = {
        PIECE_S_D, PIECE_NONE, PIECE_NONE, PIECE_S_C,
        PIECE_V_D, PIECE_S_B,  PIECE_S_A,  PIECE_V_C,
        PIECE_V_D, PIECE_H,    PIECE_H,    PIECE_V_C,
        PIECE_V_B, PIECE_BIG,  PIECE_BIG,  PIECE_V_A,
        PIECE_V_B, PIECE_BIG,  PIECE_BIG,  PIECE_V_A
    };

    // Cells 13, 14, 17 and 18.
    localparam logic [CELLS-1:0] WIN_MASK = 20'h66000;

    function automatic logic is_win(input board_t b);
        logic hit;
        hit = 1'b1;
        for (int unsigned i = 0; i < CELLS; i++) begin
            if (WIN_MASK[i] && (b[i] != PIECE_BIG)) begin
                hit = 1'b0;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/board_move_calc.sv
// Combinational move evaluator: checks legality of shifting one piece by one
// cell and produces the resulting board.
module board_move_calc
    import klotski_pkg::*;
(
    input  logic [CELLS*PIECE_W-1:0] board_i,
    input  logic [PIECE_W-1:0]       piece_i,
    input  logic [1:0]               dir_i,
    output logic                     legal_o,
    output logic [CELLS*PIECE_W-1:0] next_o
);

    board_t           board;
    board_t           nxt;
    logic             found;
    logic             off_board;
    logic             blocked;
    logic             in_bounds;
    logic [ADDR_W-1:0] tgt;
    logic             id_valid;

    always_comb begin
        board     = board_i;
        nxt       = board_i;
        found     = 1'b0;
        off_board = 1'b0;
        blocked   = 1'b0;
        in_bounds = 1'b0;
        tgt       = '0;

        // Clear first so the piece may slide into its own old cells.
        for (int unsigned i = 0; i < CELLS; i++) begin
            if (board[i] == piece_i) begin
                nxt[i] = PIECE_NONE;
            end
        end

        for (int unsigned i = 0; i < CELLS; i++) begin
            if (board[i] == piece_i) begin
                found     = 1'b1;
                in_bounds = 1'b1;
                tgt       = ADDR_W'(i);
                unique case (dir_i)
                    DirUp: begin
                        if (i < COLS) in_bounds = 1'b0;
                        else tgt = ADDR_W'(i - COLS);
                    end
                    DirDown: begin
                        if (i >= (ROWS - 1) * COLS) in_bounds = 1'b0;
                        else tgt = ADDR_W'(i + COLS);
                    end
                    DirLeft: begin
                        if ((i % COLS) == 0) in_bounds = 1'b0;
                        else tgt = ADDR_W'(i - 1);
                    end
                    DirRight: begin
                        if ((i % COLS) == COLS - 1) in_bounds = 1'b0;
                        else tgt = ADDR_W'(i + 1);
                    end
                    default: in_bounds = 1'b0;
                endcase

                if (!in_bounds) begin
                    off_board = 1'b1;
                end else begin
                    if ((board[tgt] != PIECE_NONE) && (board[tgt] != piece_i)) begin
                        blocked = 1'b1;
                    end
                    nxt[tgt] = piece_i;
                end
            end
        end

        id_valid = (piece_i != PIECE_NONE) && (piece_i <= MAX_PIECE);
        legal_o  = id_valid && found && !off_board && !blocked;
        next_o   = nxt;
    end

endmodule

// File: rtl/board_move_engine.sv
// Board RAM port-B owner: loads a shadow board, applies one move or the opening
// layout, writes the full board back, and tracks move count and win.
module board_move_engine
    import klotski_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              init_req_i,
    input  logic              move_req_i,
    input  logic [3:0]        piece_i,
    input  logic [1:0]        dir_i,
    output logic [4:0]        rd_addr_o,
    input  logic [3:0]        rd_data_i,
    output logic              wr_en_o,
    output logic [4:0]        wr_addr_o,
    output logic [3:0]        wr_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              ok_o,
    output logic [CNT_W-1:0]  move_cnt_o,
    output logic              win_o
);

    localparam logic [ADDR_W-1:0] LoadLast  = 5'd20;
    localparam logic [ADDR_W-1:0] WriteLast = 5'd19;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  step_q, step_d;
    board_t             shadow_q, shadow_d;
    logic [PIECE_W-1:0] piece_q, piece_d;
    logic [1:0]         dir_q, dir_d;
    logic               init_q, init_d;
    logic               ok_q, ok_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               win_q, win_d;

    logic                     calc_legal;
    logic [CELLS*PIECE_W-1:0] calc_next;

    board_move_calc u_calc (
        .board_i (shadow_q),
        .piece_i (piece_q),
        .dir_i   (dir_q),
        .legal_o (calc_legal),
        .next_o  (calc_next)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            step_q   <= '0;
            shadow_q <= '0;
            piece_q  <= '0;
            dir_q    <= '0;
            init_q   <= 1'b0;
            ok_q     <= 1'b0;
            cnt_q    <= '0;
            win_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            shadow_q <= shadow_d;
            piece_q  <= piece_d;
            dir_q    <= dir_d;
            init_q   <= init_d;
            ok_q     <= ok_d;
            cnt_q    <= cnt_d;
            win_q    <= win_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        shadow_d = shadow_q;
        piece_d  = piece_q;
        dir_d    = dir_q;
        init_d   = init_q;
        ok_d     = ok_q;
        cnt_d    = cnt_q;
        win_d    = win_q;

        unique case (state_q)
            StIdle: begin
                if (init_req_i) begin
                    state_d  = StWrite;
                    step_d   = '0;
                    init_d   = 1'b1;
                    shadow_d = OPENING;
                end else if (move_req_i) begin
                    state_d = StLoad;
                    step_d  = '0;
                    init_d  = 1'b0;
                    piece_d = piece_i;
                    dir_d   = dir_i;
                end
            end
            StLoad: begin
                // Read data lags the address by one cycle.
                if (step_q != '0) begin
                    shadow_d[step_q - 5'd1] = rd_data_i;
                end
                if (step_q == LoadLast) begin
                    state_d = StCheck;
                end else begin
                    step_d = step_q + 5'd1;
                end
            end
            StCheck: begin
                if (calc_legal && !win_q) begin
                    shadow_d = calc_next;
                    state_d  = StWrite;
                    step_d   = '0;
                end else begin
                    state_d = StDone;
                    ok_d    = 1'b0;
                end
            end
            StWrite: begin
                if (step_q == WriteLast) begin
                    state_d = StDone;
                    ok_d    = 1'b1;
                    if (init_q) begin
                        cnt_d = '0;
                        win_d = 1'b0;
                    end else begin
                        if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                        if (is_win(shadow_q)) win_d = 1'b1;
                    end
                end else begin
                    step_d = step_q + 5'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
                ok_d    = 1'b0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy_o     = (state_q != StIdle);
        done_o     = (state_q == StDone);
        ok_o       = ok_q;
        move_cnt_o = cnt_q;
        win_o      = win_q;
        rd_addr_o  = '0;
        wr_en_o    = 1'b0;
        wr_addr_o  = '0;
        wr_data_o  = '0;
        if ((state_q == StLoad) && (step_q != LoadLast)) begin
            rd_addr_o = step_q;
        end
        if (state_q == StWrite) begin
            wr_en_o   = 1'b1;
            wr_addr_o = step_q;
            wr_data_o = shadow_q[step_q];
        end
    end

endmodule

// File: tb/tb_board_move_engine.sv
// Self-checking bench: board RAM model, directed scenarios, then random moves
// compared against a coordinate-based reference model.
module tb_board_move_engine;

    logic       clk;
    logic       rst_n;
    logic       init_req;
    logic       move_req;
    logic [3:0] piece;
    logic [1:0] dir;
    logic [4:0] rd_addr;
    logic [3:0] rd_data;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [3:0] wr_data;
    logic       busy;
    logic       done;
    logic       ok;
    logic [9:0] move_cnt;
    logic       win;

    logic       tb_we;
    logic [4:0] tb_addr;
    logic [3:0] tb_data;
    logic [3:0] mem [20];

    int n_checks = 0;
    int n_fail   = 0;

    int m_board [20];
    int m_cnt;
    bit m_win;
    int opening [20] = '{2, 1, 1, 3, 2, 1, 1, 3, 4, 5, 5, 6, 4, 7, 8, 6, 9, 0, 0, 10};

    int op_lat, op_nwr, op_seq_err, op_busy_err, op_ok;

    board_move_engine dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .init_req_i (init_req),
        .move_req_i (move_req),
        .piece_i    (piece),
        .dir_i      (dir),
        .rd_addr_o  (rd_addr),
        .rd_data_i  (rd_data),
        .wr_en_o    (wr_en),
        .wr_addr_o  (wr_addr),
        .wr_data_o  (wr_data),
        .busy_o     (busy),
        .done_o     (done),
        .ok_o       (ok),
        .move_cnt_o (move_cnt),
        .win_o      (win)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Dual-port RAM, port B side plus a bench preload path.
    always @(posedge clk) begin
        if (tb_we) mem[tb_addr] <= tb_data;
        else if (wr_en && (wr_addr < 5'd20)) mem[wr_addr] <= wr_data;
        rd_data <= (rd_addr < 5'd20) ? mem[rd_addr] : 4'd0;
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit model_move(input int p, input int d);
        int nb [20];
        int dr, dc;
        int cells [$];
        if (p < 1 || p > 10 || m_win) return 1'b0;
        case (d)
            0: begin dr = -1; dc = 0; end
            1: begin dr = 1; dc = 0; end
            2: begin dr = 0; dc = -1; end
            default: begin dr = 0; dc = 1; end
        endcase
        for (int a = 0; a < 20; a++) if (m_board[a] == p) cells.push_back(a);
        if (cells.size() == 0) return 1'b0;
        foreach (cells[j]) begin
            int r, c;
            r = cells[j] / 4 + dr;
            c = cells[j] % 4 + dc;
            if (r < 0 || r > 4 || c < 0 || c > 3) return 1'b0;
            if (m_board[r * 4 + c] != 0 && m_board[r * 4 + c] != p) return 1'b0;
        end
        nb = m_board;
        foreach (cells[j]) nb[cells[j]] = 0;
        foreach (cells[j]) nb[(cells[j] / 4 + dr) * 4 + cells[j] % 4 + dc] = p;
        m_board = nb;
        if (m_cnt < 1023) m_cnt++;
        if (nb[13] == 1 && nb[14] == 1 && nb[17] == 1 && nb[18] == 1) m_win = 1'b1;
        return 1'b1;
    endfunction

    task automatic run_op(input logic ini, input logic mv, input logic [3:0] p,
                          input logic [1:0] d, input int inject_at);
        op_lat = -1; op_nwr = 0; op_seq_err = 0; op_busy_err = 0; op_ok = 0;
        @(negedge clk);
        init_req = ini; move_req = mv; piece = p; dir = d;
        @(posedge clk);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (k == 0) begin init_req = 1'b0; move_req = 1'b0; end
            if (k == inject_at) move_req = 1'b1;
            else if (k == inject_at + 1) move_req = 1'b0;
            if (wr_en) begin
                if (int'(wr_addr) != op_nwr) op_seq_err++;
                op_nwr++;
            end
            if (!busy) op_busy_err++;
            if (done) begin
                op_lat = k;
                op_ok  = int'(ok);
                break;
            end
        end
        move_req = 1'b0;
        if (op_lat < 0) check_eq("timeout", 1, 0);
    endtask

    task automatic verify(input int exp_ok, input int exp_lat, input int exp_nwr);
        check_eq("ok", op_ok, exp_ok);
        check_eq("latency", op_lat, exp_lat);
        check_eq("wr_count", op_nwr, exp_nwr);
        check_eq("wr_seq", op_seq_err, 0);
        check_eq("busy", op_busy_err, 0);
        check_eq("move_cnt", int'(move_cnt), m_cnt);
        check_eq("win", int'(win), int'(m_win));
        for (int i = 0; i < 20; i++) check_eq("ram_cell", int'(mem[i]), m_board[i]);
    endtask

    task automatic do_init();
        m_board = opening; m_cnt = 0; m_win = 1'b0;
        run_op(1'b1, 1'b0, 4'd0, 2'd0, -1);
        verify(1, 20, 20);
    endtask

    task automatic do_move(input int p, input int d);
        bit exp;
        exp = model_move(p, d);
        run_op(1'b0, 1'b1, 4'(p), 2'(d), -1);
        verify(int'(exp), exp ? 42 : 22, exp ? 20 : 0);
    endtask

    task automatic preload(input int b [20]);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            tb_we = 1'b1; tb_addr = 5'(i); tb_data = 4'(b[i]);
        end
        @(negedge clk);
        tb_we = 1'b0;
        m_board = b;
    endtask

    initial begin
        int wb [20];
        int p, d;
        rst_n = 1'b0; init_req = 1'b0; move_req = 1'b0; piece = '0; dir = '0;
        tb_we = 1'b0; tb_addr = '0; tb_data = '0;
        m_cnt = 0; m_win = 1'b0;
        #12;
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_wr_en", int'(wr_en), 0);
        check_eq("rst_move_cnt", int'(move_cnt), 0);
        check_eq("rst_win", int'(win), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Opening layout, then a legal slide of piece 9 to the right.
        do_init();
        do_move(9, 3);
        check_eq("cell16", int'(mem[16]), 0);
        check_eq("cell17", int'(mem[17]), 9);
        check_eq("cnt_after_move", int'(move_cnt), 1);

        // Rejections from the opening layout.
        do_init();
        do_move(1, 0);
        do_move(10, 3);
        do_move(0, 1);
        do_move(5, 1);
        do_move(12, 2);

        // Both requests together: init wins.
        do_move(7, 1);
        m_board = opening; m_cnt = 0; m_win = 1'b0;
        run_op(1'b1, 1'b1, 4'd9, 2'd3, -1);
        verify(1, 20, 20);

        // Move request in the middle of a write sequence is dropped.
        do_move(9, 3);
        m_board = opening; m_cnt = 0; m_win = 1'b0;
        run_op(1'b1, 1'b0, 4'd9, 2'd3, 5);
        verify(1, 20, 20);
        @(negedge clk);
        @(negedge clk);
        check_eq("ignored_busy", int'(busy), 0);

        // Winning slide, then everything rejected until init.
        wb = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0};
        preload(wb);
        do_move(1, 1);
        check_eq("win_set", int'(win), 1);
        do_move(1, 0);
        do_init();
        check_eq("win_cleared", int'(win), 0);

        // Asynchronous reset in the middle of a write sequence.
        do_move(9, 3);
        @(negedge clk);
        init_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        init_req = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check_eq("pre_rst_wr_en", int'(wr_en), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_busy", int'(busy), 0);
        check_eq("mid_rst_wr_en", int'(wr_en), 0);
        check_eq("mid_rst_wr_addr", int'(wr_addr), 0);
        check_eq("mid_rst_wr_data", int'(wr_data), 0);
        check_eq("mid_rst_rd_addr", int'(rd_addr), 0);
        check_eq("mid_rst_done", int'(done), 0);
        check_eq("mid_rst_ok", int'(ok), 0);
        check_eq("mid_rst_move_cnt", int'(move_cnt), 0);
        check_eq("mid_rst_win", int'(win), 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_init();

        // Random play, mostly valid piece ids.
        for (int n = 0; n < 60; n++) begin
            if (n % 20 == 19) do_init();
            if ($urandom_range(0, 7) == 0) p = int'($urandom_range(0, 15));
            else p = int'($urandom_range(1, 10));
            d = int'($urandom_range(0, 3));
            do_move(p, d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
